// File: rtl/spi_matrix_host_if.sv
// Host-side bus of the SPI matrix streaming master: command, tx/rx word
// handshakes and the four SPI pins.
interface spi_matrix_host_if #(
  parameter int WORD_W    = 32,
  parameter int MAX_WORDS = 200
);
  localparam int CW = $clog2(MAX_WORDS) + 1;

  logic              start;
  logic [CW-1:0]     word_count;
  logic [WORD_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              done;
  logic              sclk;
  logic              mosi;
  logic              cs_n;
  logic              miso;

  modport master (
    input  start, word_count, tx_data, tx_valid, miso,
    output tx_ready, rx_data, rx_valid, busy, done, sclk, mosi, cs_n
  );

  modport slave (
    output start, word_count, tx_data, tx_valid, miso,
    input  tx_ready, rx_data, rx_valid, busy, done, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_matrix_host.sv
// SPI mode-0 master: one start gives one cs_n frame of word_count full-duplex
// WORD_W-bit words, MSB first, sclk half-period of CLK_DIV clk cycles.
//
// state | meaning
// IDLE  | cs_n high, waiting for start
// LOAD  | cs_n low, sclk idle, tx_ready high until a word is taken
// SHIFT | clocking one word out on mosi / in from miso
// TAIL  | cs_n held low CLK_DIV cycles after the last sclk fall
module spi_matrix_host #(
  parameter int CLK_DIV   = 4,
  parameter int WORD_W    = 32,
  parameter int MAX_WORDS = 200
) (
  input  logic              clk,
  input  logic              rst,
  spi_matrix_host_if.master bus
);
  localparam int CW = $clog2(MAX_WORDS) + 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(WORD_W);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, TAIL} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-2:0] tx_sr_q, tx_sr_d;
  logic [WORD_W-2:0] rx_sr_q, rx_sr_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [CW-1:0]     words_q, words_d;
  logic [CW-1:0]     count_q, count_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              tx_ready_q, tx_ready_d;
  logic              rx_valid_q, rx_valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    div_d      = div_q;
    bit_d      = bit_q;
    words_d    = words_q;
    count_d    = count_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    tx_ready_d = tx_ready_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        mosi_d = 1'b0;
        cs_n_d = 1'b1;
        if (bus.start) begin
          if (bus.word_count != '0) begin
            // Oversized counts saturate so the frame still terminates.
            count_d    = (bus.word_count > MAX_CNT) ? MAX_CNT : bus.word_count;
            words_d    = '0;
            cs_n_d     = 1'b0;
            busy_d     = 1'b1;
            tx_ready_d = 1'b1;
            state_d    = LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (bus.tx_valid && tx_ready_q) begin
          mosi_d     = bus.tx_data[WORD_W-1];
          tx_sr_d    = bus.tx_data[WORD_W-2:0];
          tx_ready_d = 1'b0;
          div_d      = '0;
          bit_d      = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            rx_sr_d = {rx_sr_q[WORD_W-3:0], bus.miso};
            if (bit_q == BIT_LAST) begin
              rx_data_d  = {rx_sr_q, bus.miso};
              rx_valid_d = 1'b1;
            end
          end else begin
            sclk_d  = 1'b0;
            mosi_d  = tx_sr_q[WORD_W-2];
            tx_sr_d = {tx_sr_q[WORD_W-3:0], 1'b0};
            bit_d   = bit_q + BW'(1);
            if (bit_q == BIT_LAST) begin
              words_d = words_q + CW'(1);
              if (words_q + CW'(1) >= count_q) begin
                state_d = TAIL;
              end else begin
                tx_ready_d = 1'b1;
                state_d    = LOAD;
              end
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      TAIL: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      words_q    <= '0;
      count_q    <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      words_q    <= words_d;
      count_q    <= count_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.sclk     = sclk_q;
  assign bus.mosi     = mosi_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_spi_matrix_host.sv
// Bench for spi_matrix_host: cycle-timeline reference model checked every
// cycle, a mode-0 slave (loopback or fixed reply) and directed frames.
module tb_spi_matrix_host;
  localparam int CLK_DIV   = 2;
  localparam int WORD_W    = 32;
  localparam int MAX_WORDS = 200;
  localparam int CW        = $clog2(MAX_WORDS) + 1;
  localparam int D2        = 2 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_matrix_host_if #(.WORD_W(WORD_W), .MAX_WORDS(MAX_WORDS)) bus ();

  spi_matrix_host #(.CLK_DIV(CLK_DIV), .WORD_W(WORD_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Slave: loopback (miso = mosi) or replies slave_word, changing on sclk fall.
  logic        slave_mode = 1'b0;
  logic [31:0] slave_word = '0;
  logic [7:0]  s_falls    = '0;
  logic [31:0] s_cap      = '0;
  logic [4:0]  s_idx;
  int          rises      = 0;
  int          csn_rises  = 0;

  always @(negedge bus.sclk or posedge bus.cs_n)
    if (bus.cs_n) s_falls <= '0;
    else          s_falls <= s_falls + 8'd1;

  always @(posedge bus.sclk) begin
    s_cap <= {s_cap[30:0], bus.mosi};
    rises <= rises + 1;
  end

  always @(posedge bus.cs_n) csn_rises <= csn_rises + 1;

  assign s_idx    = 5'd31 - s_falls[4:0];
  assign bus.miso = slave_mode ? slave_word[s_idx] : bus.mosi;

  // Reference: m_k counts cycles since a word was taken; bit = m_k/(2*CLK_DIV),
  // sclk high in the second half of each bit period.
  logic        m_busy = 1'b0, m_ready = 1'b0, e_done = 1'b0, e_rxv = 1'b0, e_sclk;
  int          m_k = -1, m_tail = -1, m_left = 0;
  logic [31:0] m_word = '0, m_resp = '0, e_rx = '0;
  int          rxv_cnt = 0, done_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 1'b0; m_ready = 1'b0; m_k = -1; m_tail = -1; m_left = 0;
        e_done = 1'b0; e_rxv = 1'b0; e_rx = '0;
      end else begin
        e_done = 1'b0;
        e_rxv  = 1'b0;
        if (!m_busy) begin
          if (bus.start) begin
            if (bus.word_count != '0) begin
              m_busy  = 1'b1;
              m_ready = 1'b1;
              m_left  = (int'(bus.word_count) > MAX_WORDS) ? MAX_WORDS : int'(bus.word_count);
            end else begin
              e_done = 1'b1;
            end
          end
        end else if (m_ready) begin
          if (bus.tx_valid) begin
            m_ready = 1'b0;
            m_k     = 0;
            m_word  = bus.tx_data;
            m_resp  = slave_mode ? slave_word : bus.tx_data;
          end
        end else if (m_k >= 0) begin
          m_k++;
          if (m_k == 63 * CLK_DIV) begin
            e_rxv = 1'b1;
            e_rx  = m_resp;
          end
          if (m_k == 64 * CLK_DIV) begin
            m_k = -1;
            m_left--;
            if (m_left > 0) m_ready = 1'b1;
            else            m_tail  = 0;
          end
        end else begin
          m_tail++;
          if (m_tail == CLK_DIV) begin
            m_tail = -1;
            m_busy = 1'b0;
            e_done = 1'b1;
          end
        end
      end
      @(negedge clk);
      e_sclk = (m_k >= 0) && ((m_k % D2) >= CLK_DIV);
      chk("cs_n",     32'(bus.cs_n),     32'(!m_busy));
      chk("busy",     32'(bus.busy),     32'(m_busy));
      chk("tx_ready", 32'(bus.tx_ready), 32'(m_ready));
      chk("done",     32'(bus.done),     32'(e_done));
      chk("rx_valid", 32'(bus.rx_valid), 32'(e_rxv));
      chk("rx_data",  bus.rx_data,       e_rx);
      chk("sclk",     32'(bus.sclk),     32'(e_sclk));
      if (m_k >= 0)     chk("mosi",      32'(bus.mosi), 32'(m_word[31 - m_k / D2]));
      else if (!m_busy) chk("mosi_idle", 32'(bus.mosi), 32'd0);
      if (bus.rx_valid) rxv_cnt++;
      if (bus.done)     done_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int wc);
    bus.word_count = CW'(wc);
    bus.start      = 1'b1;
    cyc(1);
    bus.start      = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int stall);
    int n = 0;
    while (!bus.tx_ready && n < 1000) begin cyc(1); n++; end
    chk("tx_ready_wait", 32'(bus.tx_ready), 32'd1);
    for (int s = 0; s < stall; s++) begin
      cyc(1);
      chk("stall_sclk", 32'(bus.sclk), 32'd0);
      chk("stall_cs_n", 32'(bus.cs_n), 32'd0);
    end
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    cyc(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 2000) begin cyc(1); n++; end
    chk(name, 32'(bus.done), 32'd1);
  endtask

  int r0, v0, d0, k0;

  initial begin
    bus.start = 1'b0; bus.word_count = '0; bus.tx_data = '0; bus.tx_valid = 1'b0;
    rst = 1'b1;
    cyc(3);
    chk("rst_cs_n",     32'(bus.cs_n),     32'd1);
    chk("rst_sclk",     32'(bus.sclk),     32'd0);
    chk("rst_mosi",     32'(bus.mosi),     32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    chk("rst_done",     32'(bus.done),     32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_rx_data",  bus.rx_data,       32'd0);
    rst = 1'b0;
    cyc(2);

    // 1: loopback single word
    r0 = rises; v0 = rxv_cnt;
    start_frame(1);
    send_word(32'hA5A50F0F, 0);
    wait_done("t1_done");
    chk("t1_cs_n_at_done", 32'(bus.cs_n), 32'd1);
    chk("t1_busy_at_done", 32'(bus.busy), 32'd0);
    chk("t1_rises",        32'(rises - r0), 32'd32);
    chk("t1_rx_data",      bus.rx_data, 32'hA5A50F0F);
    chk("t1_rxv_pulses",   32'(rxv_cnt - v0), 32'd1);
    cyc(3);

    // 2: slave replies a fixed word
    slave_mode = 1'b1; slave_word = 32'h12345678;
    k0 = csn_rises;
    start_frame(1);
    send_word(32'hDEADBEEF, 0);
    wait_done("t2_done");
    chk("t2_slave_cap",  s_cap, 32'hDEADBEEF);
    chk("t2_rx_data",    bus.rx_data, 32'h12345678);
    chk("t2_cs_n_rises", 32'(csn_rises - k0), 32'd1);
    slave_mode = 1'b0;
    cyc(3);

    // 3: three words with a 10-cycle stall before word 2
    r0 = rises; v0 = rxv_cnt;
    start_frame(3);
    send_word(32'h0F1E2D3C, 0);
    send_word(32'hCAFEF00D, 10);
    send_word(32'h80000001, 0);
    wait_done("t3_done");
    chk("t3_rises",      32'(rises - r0), 32'd96);
    chk("t3_rxv_pulses", 32'(rxv_cnt - v0), 32'd3);
    chk("t3_rx_data",    bus.rx_data, 32'h80000001);
    cyc(3);

    // 4: zero-length frame
    r0 = rises; k0 = csn_rises;
    start_frame(0);
    chk("t4_done",      32'(bus.done), 32'd1);
    chk("t4_cs_n",      32'(bus.cs_n), 32'd1);
    chk("t4_busy",      32'(bus.busy), 32'd0);
    cyc(1);
    chk("t4_done_once", 32'(bus.done), 32'd0);
    chk("t4_no_sclk",   32'(rises - r0), 32'd0);
    chk("t4_no_cs_n",   32'(csn_rises - k0), 32'd0);
    cyc(2);

    // 5: reset after 17 bits, then a clean frame
    r0 = rises; v0 = rxv_cnt; d0 = done_cnt;
    start_frame(1);
    send_word(32'hF00FF00F, 0);
    for (int i = 0; i < 2000 && (rises - r0) < 17; i++) cyc(1);
    chk("t5_reach17", 32'(rises - r0), 32'd17);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t5_cs_n",     32'(bus.cs_n),     32'd1);
    chk("t5_sclk",     32'(bus.sclk),     32'd0);
    chk("t5_mosi",     32'(bus.mosi),     32'd0);
    chk("t5_busy",     32'(bus.busy),     32'd0);
    chk("t5_tx_ready", 32'(bus.tx_ready), 32'd0);
    chk("t5_rx_data",  bus.rx_data,       32'd0);
    cyc(6);
    chk("t5_no_rxv",  32'(rxv_cnt - v0),  32'd0);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    start_frame(1);
    send_word(32'h3C3C5AA5, 0);
    wait_done("t5_done");
    chk("t5_rx_after", bus.rx_data, 32'h3C3C5AA5);
    chk("t5_rxv_after", 32'(rxv_cnt - v0), 32'd1);
    cyc(3);

    // 6: start while busy ignored; back-to-back start on the done cycle
    v0 = rxv_cnt;
    start_frame(1);
    send_word(32'h13579BDF, 0);
    cyc(20);
    bus.word_count = CW'(5);
    bus.start      = 1'b1;
    cyc(1);
    bus.start      = 1'b0;
    chk("t6_busy_kept", 32'(bus.busy), 32'd1);
    wait_done("t6_done1");
    chk("t6_cs_n_gap", 32'(bus.cs_n), 32'd1);
    bus.word_count = CW'(1);
    bus.start      = 1'b1;
    cyc(1);
    bus.start      = 1'b0;
    chk("t6_cs_n_low_next", 32'(bus.cs_n), 32'd0);
    chk("t6_busy_next",     32'(bus.busy), 32'd1);
    send_word(32'h2468ACE0, 0);
    wait_done("t6_done2");
    chk("t6_rxv_pulses", 32'(rxv_cnt - v0), 32'd2);
    chk("t6_rx_data",    bus.rx_data, 32'h2468ACE0);
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
